// File: rtl/iic_master_byte_engine_if.sv
// Command/response port of the IIC master byte engine.
// The controller FSM connects through the master modport and the engine through the slave modport.
interface iic_master_byte_engine_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] wr_data;
  logic       rd_nack;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       ack_err;
  logic       busy;

  modport master (
    output cmd, cmd_valid, wr_data, rd_nack,
    input  cmd_ready, rd_data, rd_valid, ack_err, busy
  );

  modport slave (
    input  cmd, cmd_valid, wr_data, rd_nack,
    output cmd_ready, rd_data, rd_valid, ack_err, busy
  );
endinterface

// File: rtl/iic_master_byte_engine.sv
// Command-driven I2C master: executes START / WRITE / READ / STOP, open-drain SCL and SDA.
// Define IIC_MASTER_STRETCH_EN to let a slave stretch SCL before each high phase is timed.
module iic_master_byte_engine #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  inout  wire                      SCL,
  inout  wire                      SDA,
  iic_master_byte_engine_if.slave  bus
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CntLast = CW'(CLK_DIV - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StBit   = 3'd2;
  localparam logic [2:0] StStop  = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdWrite = 3'd2;
  localparam logic [2:0] CmdRead  = 3'd3;
  localparam logic [2:0] CmdStop  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    rx_q, rx_d;
  logic          is_read_q, is_read_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          ack_err_q, ack_err_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          scl_low_q, scl_low_d;
  logic          sda_low_q, sda_low_d;

  logic cmd_ready;
  logic accept;
  logic phase_end;
  logic stall;
  logic sda_in;

  assign SCL    = scl_low_q ? 1'b0 : 1'bz;
  assign SDA    = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in = SDA;

`ifdef IIC_MASTER_STRETCH_EN
  logic scl_in;
  assign scl_in = SCL;
  // Q1 timing starts only once the line actually reads high.
  assign stall  = (phase_q == 2'd1) && (cnt_q == '0) && !scl_in;
`else
  assign stall  = 1'b0;
`endif

  assign cmd_ready = (state_q == StIdle);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign phase_end = (cnt_q == CntLast);

  assign bus.cmd_ready = cmd_ready;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ack_err   = ack_err_q;
  assign bus.busy      = busy_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    is_read_d  = is_read_q;
    nack_d     = nack_q;
    busy_d     = busy_q;
    ack_err_d  = ack_err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          phase_d = 2'd0;
          cnt_d   = '0;
          bit_d   = 4'd0;
          case (bus.cmd)
            CmdStart: begin
              state_d   = StStart;
              ack_err_d = 1'b0;
            end
            CmdWrite, CmdRead: begin
              if (busy_q) begin
                state_d   = StBit;
                is_read_d = (bus.cmd == CmdRead);
                tx_d      = bus.wr_data;
                nack_d    = bus.rd_nack;
              end else begin
                state_d   = StDone;
                ack_err_d = 1'b1;
              end
            end
            CmdStop: state_d = busy_q ? StStop : StDone;
            default: state_d = StDone;
          endcase
        end
      end

      StStart, StBit, StStop: begin
        if (phase_end) begin
          cnt_d   = '0;
          phase_d = phase_q + 2'd1;
          if ((state_q == StBit) && (phase_q == 2'd1)) begin
            if (bit_q == 4'd8) begin
              if (!is_read_q) ack_err_d = sda_in;
            end else begin
              rx_d = {rx_q[6:0], sda_in};
            end
          end
          if (phase_q == 2'd3) begin
            bit_d = bit_q + 4'd1;
            tx_d  = {tx_q[6:0], 1'b0};
            if ((state_q != StBit) || (bit_q == 4'd8)) begin
              state_d = StDone;
              if (state_q == StStart) busy_d = 1'b1;
              if (state_q == StStop)  busy_d = 1'b0;
              if ((state_q == StBit) && is_read_q) begin
                rd_valid_d = 1'b1;
                rd_data_d  = rx_q;
              end
            end
          end
        end else if (!stall) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Line levels are derived from the phase being entered, so they only change at phase starts.
  // Outside a command both lines keep their last level, which holds SCL low while the bus is owned.
  always_comb begin
    scl_low_d = scl_low_q;
    sda_low_d = sda_low_q;
    unique case (state_d)
      StStart: begin
        scl_low_d = (phase_d == 2'd0) ? busy_q : (phase_d == 2'd3);
        sda_low_d = phase_d[1];
      end
      StBit: begin
        scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
        if (bit_d == 4'd8) begin
          sda_low_d = is_read_d & ~nack_d;
        end else begin
          sda_low_d = ~is_read_d & ~tx_d[7];
        end
      end
      StStop: begin
        scl_low_d = (phase_d == 2'd0);
        sda_low_d = ~phase_d[1];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= StIdle;
      phase_q    <= 2'd0;
      bit_q      <= 4'd0;
      cnt_q      <= '0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      is_read_q  <= 1'b0;
      nack_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      scl_low_q  <= 1'b0;
      sda_low_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      is_read_q  <= is_read_d;
      nack_q     <= nack_d;
      busy_q     <= busy_d;
      ack_err_q  <= ack_err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      scl_low_q  <= scl_low_d;
      sda_low_q  <= sda_low_d;
    end
  end

endmodule
